// File: rtl/uart_param_collector_if.sv
// Bus between the UART word source, the parameter collector and the pricing-core consumer.
interface uart_param_collector_if #(
  parameter int NUM_PARAMS = 7
);
  localparam int CW = $clog2(NUM_PARAMS + 1);

  logic                    rx_valid;
  logic [31:0]             rx_data;
  logic                    params_valid;
  logic                    params_ready;
  logic [32*NUM_PARAMS-1:0] params_out;
  logic [CW-1:0]           word_cnt;
  logic                    timeout_err;
  logic                    overrun;

  modport slave (
    input  rx_valid, rx_data, params_ready,
    output params_valid, params_out, word_cnt, timeout_err, overrun
  );

  modport master (
    output rx_valid, rx_data, params_ready,
    input  params_valid, params_out, word_cnt, timeout_err, overrun
  );
endinterface

// File: rtl/uart_param_collector.sv
// Frames SYNC_WORD + NUM_PARAMS payload words from uart_rx32 into one parameter bundle
// with valid/ready hand-off, inter-word timeout and sticky overrun.
//
//   state     | meaning
//   S_IDLE    | waiting for SYNC_WORD; other words dropped silently
//   S_COLLECT | storing payload words into shadow slots, timer running
//   S_HOLD    | bundle presented on params_out until accepted
module uart_param_collector #(
  parameter int          NUM_PARAMS     = 7,
  parameter logic [31:0] SYNC_WORD      = 32'hA5A5_5A5A,
  parameter int          TIMEOUT_CYCLES = 200_000
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_param_collector_if.slave  bus
);
  localparam int CW = $clog2(NUM_PARAMS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            word_cnt_q;
  logic [TW-1:0]            timer_q;
  logic [31:0]              shadow_q [NUM_PARAMS];
  logic [32*NUM_PARAMS-1:0] params_q;
  logic                     valid_q;
  logic                     tmo_q;
  logic                     ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      timer_q    <= '0;
      params_q   <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_data == SYNC_WORD) begin
            state_q    <= S_COLLECT;
            word_cnt_q <= '0;
            timer_q    <= '0;
          end
        end
        S_COLLECT: begin
          if (bus.rx_valid) begin
            timer_q                <= '0;
            shadow_q[word_cnt_q]   <= bus.rx_data;
            word_cnt_q             <= word_cnt_q + 1'b1;
            if (word_cnt_q == CW'(NUM_PARAMS - 1)) begin
              // last word bypasses the shadow so the bundle is valid one edge later
              for (int i = 0; i < NUM_PARAMS; i++) begin
                params_q[32*i +: 32] <= (i == NUM_PARAMS - 1) ? bus.rx_data : shadow_q[i];
              end
              valid_q <= 1'b1;
              state_q <= S_HOLD;
            end
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_q      <= 1'b1;
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            timer_q    <= '0;
          end else if (timer_q != TW'(TIMEOUT_CYCLES)) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.rx_valid) ovr_q <= 1'b1;
          if (bus.params_ready) begin
            valid_q    <= 1'b0;
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.params_valid = valid_q;
  assign bus.params_out   = params_q;
  assign bus.word_cnt     = word_cnt_q;
  assign bus.timeout_err  = tmo_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_uart_param_collector.sv
// Directed bench for uart_param_collector: framing, garbage rejection, timeout, overrun, reset.
module tb_uart_param_collector;
  localparam int          NP   = 7;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;
  localparam int          TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0]     w1 [NP];
  logic [31:0]     w5 [NP];
  logic [32*NP-1:0] bundle1;
  logic [32*NP-1:0] bundle5;

  always #5 clk = ~clk;

  uart_param_collector_if #(.NUM_PARAMS(NP)) bus ();

  uart_param_collector #(
    .NUM_PARAMS(NP),
    .SYNC_WORD(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic send_frame(input logic [31:0] w [NP]);
    send_word(SYNC);
    for (int i = 0; i < NP; i++) send_word(w[i]);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.params_ready = 1'b1;
    @(negedge clk);
    bus.params_ready = 1'b0;
  endtask

  function automatic logic [32*NP-1:0] pack(input logic [31:0] w [NP]);
    logic [32*NP-1:0] r;
    for (int i = 0; i < NP; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  initial begin
    w1 = '{32'h0000_2710, 32'h0000_0032, 32'h0064_0000, 32'h0064_0000,
           32'h0000_CCC0, 32'h0003_3333, 32'h0001_0000};
    w5 = '{32'h1111_0001, 32'h2222_0002, 32'hA5A5_5A5A, 32'h4444_0004,
           32'h5555_0005, 32'h6666_0006, 32'h7777_0007};
    bundle1 = 224'h00010000_00033333_0000CCC0_00640000_00640000_00000032_00002710;
    bundle5 = pack(w5);

    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    bus.params_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("rst_valid",   256'(bus.params_valid), 256'(0));
    check_val("rst_params",  256'(bus.params_out),   256'(0));
    check_val("rst_cnt",     256'(bus.word_cnt),     256'(0));
    check_val("rst_tmo",     256'(bus.timeout_err),  256'(0));
    check_val("rst_ovr",     256'(bus.overrun),      256'(0));

    // test 1: basic frame, ready raised late
    send_word(SYNC);
    for (int i = 0; i < NP - 1; i++) send_word(w1[i]);
    check_val("t1_cnt6",   256'(bus.word_cnt),     256'(6));
    check_val("t1_valid6", 256'(bus.params_valid), 256'(0));
    send_word(w1[NP-1]);
    check_val("t1_valid",  256'(bus.params_valid), 256'(1));
    check_val("t1_bundle", 256'(bus.params_out),   256'(bundle1));
    check_val("t1_cnt7",   256'(bus.word_cnt),     256'(7));
    repeat (4) @(negedge clk);
    check_val("t1_hold",   256'(bus.params_valid), 256'(1));
    handshake();
    check_val("t1_accept", 256'(bus.params_valid), 256'(0));
    check_val("t1_cnt0",   256'(bus.word_cnt),     256'(0));

    // test 2: garbage before header
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    check_val("t2_cnt_idle", 256'(bus.word_cnt), 256'(0));
    send_frame(w1);
    check_val("t2_valid",  256'(bus.params_valid), 256'(1));
    check_val("t2_bundle", 256'(bus.params_out),   256'(bundle1));
    check_val("t2_ovr",    256'(bus.overrun),      256'(0));
    handshake();

    // test 3: timeout 1000 cycles after the 3rd payload word
    send_word(SYNC);
    for (int i = 0; i < 3; i++) send_word(w5[i]);
    repeat (TMO - 1) @(negedge clk);
    check_val("t3_tmo_early", 256'(bus.timeout_err), 256'(0));
    check_val("t3_cnt3",      256'(bus.word_cnt),    256'(3));
    @(negedge clk);
    check_val("t3_tmo",       256'(bus.timeout_err),  256'(1));
    check_val("t3_cnt0",      256'(bus.word_cnt),     256'(0));
    check_val("t3_valid",     256'(bus.params_valid), 256'(0));
    check_val("t3_keep",      256'(bus.params_out),   256'(bundle1));
    @(negedge clk);
    check_val("t3_tmo_pulse", 256'(bus.timeout_err), 256'(0));
    send_frame(w1);
    check_val("t3_bundle", 256'(bus.params_out),   256'(bundle1));
    check_val("t3_valid2", 256'(bus.params_valid), 256'(1));

    // test 4: word during HOLD sets sticky overrun
    send_word(32'h0000_FFFF);
    check_val("t4_ovr",    256'(bus.overrun),      256'(1));
    check_val("t4_bundle", 256'(bus.params_out),   256'(bundle1));
    check_val("t4_valid",  256'(bus.params_valid), 256'(1));
    handshake();
    check_val("t4_ovr_sticky", 256'(bus.overrun),  256'(1));

    // test 5: SYNC_WORD inside payload is data
    send_frame(w5);
    check_val("t5_valid",  256'(bus.params_valid), 256'(1));
    check_val("t5_bundle", 256'(bus.params_out),   256'(bundle5));
    handshake();

    // test 6: reset mid-frame
    send_word(SYNC);
    for (int i = 0; i < 4; i++) send_word(w5[i]);
    check_val("t6_cnt4", 256'(bus.word_cnt), 256'(4));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t6_valid",  256'(bus.params_valid), 256'(0));
    check_val("t6_params", 256'(bus.params_out),   256'(0));
    check_val("t6_cnt",    256'(bus.word_cnt),     256'(0));
    check_val("t6_ovr",    256'(bus.overrun),      256'(0));
    send_frame(w1);
    check_val("t6_bundle", 256'(bus.params_out),   256'(bundle1));
    check_val("t6_valid2", 256'(bus.params_valid), 256'(1));
    check_val("t6_ovr2",   256'(bus.overrun),      256'(0));
    handshake();
    check_val("t6_accept", 256'(bus.params_valid), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
